// File: rtl/prescaler_monitor.sv
// Health checker for an N-bit prescaler output: measures period and high time of
// sig_in in clk_in cycles, tracks lock against 2^N / 2^(N-1), flags errors and loss of signal.
module prescaler_monitor #(
    parameter int N        = 2,
    parameter int W        = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic         clk_in,
    input  logic         rstn,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         period_valid,
    output logic         locked,
    output logic         err,
    output logic [7:0]   err_count,
    output logic         timeout,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [W-1:0] EXP_PERIOD  = W'(2 ** N);
    localparam logic [W-1:0] EXP_HIGH    = W'(2 ** (N - 1));
    localparam logic [W-1:0] TIMEOUT_CNT = W'(2 ** (N + 2));
    localparam logic [3:0]   LOCK_LAST   = 4'(LOCK_CNT - 1);

    state_t       state;
    logic         sig_q;
    logic [W-1:0] cnt;
    logic [W-1:0] hcnt;
    logic [W-1:0] hcap;
    logic [3:0]   goodcnt;
    logic         rise;
    logic         fall;
    logic         good;

    assign rise      = sig_in & ~sig_q;
    assign fall      = ~sig_in & sig_q;
    // A saturated cnt is all-ones and can never equal 2^N, so overflow is never good.
    assign good      = (cnt == EXP_PERIOD) && (hcap == EXP_HIGH);
    assign state_dbg = state;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            sig_q <= 1'b0;
            cnt   <= '0;
            hcnt  <= '0;
            hcap  <= '0;
        end else begin
            sig_q <= sig_in;
            if (rise) begin
                cnt <= W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (rise) begin
                hcnt <= W'(1);
            end else if (sig_in && hcnt != '1) begin
                hcnt <= hcnt + 1'b1;
            end
            if (fall) begin
                hcap <= hcnt;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state        <= SEEK;
            goodcnt      <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_count    <= '0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            case (state)
                SEEK: begin
                    if (rise) begin
                        state   <= ACQUIRE;
                        timeout <= 1'b0;
                    end
                end
                ACQUIRE, LOCKED: begin
                    // A rise wins over a timeout landing on the same cycle.
                    if (rise) begin
                        period       <= cnt;
                        high_time    <= hcap;
                        period_valid <= 1'b1;
                        if (good) begin
                            if (state == ACQUIRE) begin
                                goodcnt <= goodcnt + 1'b1;
                                if (goodcnt == LOCK_LAST) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            err     <= 1'b1;
                            goodcnt <= '0;
                            locked  <= 1'b0;
                            state   <= ACQUIRE;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout <= 1'b1;
                        err     <= 1'b1;
                        goodcnt <= '0;
                        locked  <= 1'b0;
                        state   <= SEEK;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                default: state <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_prescaler_monitor.sv
// Directed bench for prescaler_monitor with N=2, LOCK_CNT=4: lock, period/duty faults,
// timeout, asynchronous reset and err_count saturation.
module tb_prescaler_monitor;

    localparam int N        = 2;
    localparam int W        = 16;
    localparam int LOCK_CNT = 4;

    logic         clk_in;
    logic         rstn;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic         locked;
    logic         err;
    logic [7:0]   err_count;
    logic         timeout;
    logic [1:0]   state_dbg;

    int checks     = 0;
    int failures   = 0;
    int err_seen   = 0;
    int valid_seen = 0;

    // Outputs captured right after the rising-edge cycle of each send_period call.
    logic [W-1:0] rv_period;
    logic [W-1:0] rv_high;
    logic         rv_valid;
    logic         rv_err;
    logic         rv_locked;
    logic         rv_timeout;
    logic [7:0]   rv_errcnt;
    logic [1:0]   rv_state;

    prescaler_monitor #(.N(N), .W(W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk_in       (clk_in),
        .rstn         (rstn),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err),
        .err_count    (err_count),
        .timeout      (timeout),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clk_in cycle with sig_in = v; outputs are sampled 1ns after the edge.
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk_in);
        #1;
        if (err) err_seen++;
        if (period_valid) valid_seen++;
    endtask

    task automatic send_period(input int hi, input int lo);
        step(1'b1);
        rv_period  = period;
        rv_high    = high_time;
        rv_valid   = period_valid;
        rv_err     = err;
        rv_locked  = locked;
        rv_timeout = timeout;
        rv_errcnt  = err_count;
        rv_state   = state_dbg;
        for (int i = 1; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    initial begin
        int e0;
        rstn   = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_state", state_dbg, 0);
        rstn = 1'b1;

        // Nominal divide-by-4: bit1 of a free-running 2-bit counter.
        step(1'b0);
        step(1'b0);
        send_period(2, 2);
        check("s2_rise1_valid", rv_valid, 0);
        check("s2_rise1_state", rv_state, 1);
        send_period(2, 2);
        check("s2_rise2_valid", rv_valid, 1);
        check("s2_rise2_period", rv_period, 4);
        check("s2_rise2_high", rv_high, 2);
        check("s2_rise2_locked", rv_locked, 0);
        send_period(2, 2);
        send_period(2, 2);
        check("s2_rise4_locked", rv_locked, 0);
        send_period(2, 2);
        check("s2_rise5_locked", rv_locked, 1);
        check("s2_rise5_state", rv_state, 2);
        send_period(2, 2);
        check("s2_rise6_locked", rv_locked, 1);
        check("s2_no_err", err_seen, 0);
        check("s2_valid_count", valid_seen, 5);

        // Stretched low phase: period 5 reported on the following rise.
        send_period(2, 3);
        check("s3_pre_locked", rv_locked, 1);
        e0 = err_seen;
        send_period(2, 2);
        check("s3_period", rv_period, 5);
        check("s3_err", rv_err, 1);
        check("s3_errcnt", rv_errcnt, 1);
        check("s3_locked", rv_locked, 0);
        check("s3_state", rv_state, 1);
        check("s3_err_single", err_seen - e0, 1);
        send_period(2, 2);
        send_period(2, 2);
        send_period(2, 2);
        check("s3_relock3", rv_locked, 0);
        send_period(2, 2);
        check("s3_relock4", rv_locked, 1);

        // Duty fault: high 3 / low 1.
        send_period(3, 1);
        check("s4_pre_locked", rv_locked, 1);
        send_period(2, 2);
        check("s4_period", rv_period, 4);
        check("s4_high", rv_high, 3);
        check("s4_err", rv_err, 1);
        check("s4_locked", rv_locked, 0);
        check("s4_errcnt", rv_errcnt, 2);

        // Loss of signal: rise, then held low.
        step(1'b1);
        step(1'b1);
        for (int k = 2; k <= 15; k++) step(1'b0);
        check("s5_no_timeout_15", timeout, 0);
        step(1'b0);
        check("s5_timeout_16", timeout, 1);
        check("s5_err", err, 1);
        check("s5_locked", locked, 0);
        check("s5_period_kept", period, 4);
        check("s5_errcnt", err_count, 3);
        check("s5_state", state_dbg, 0);
        step(1'b0);
        check("s5_timeout_held", timeout, 1);
        check("s5_err_single", err, 0);
        repeat (5) step(1'b0);
        send_period(2, 2);
        check("s5_rise_clear", rv_timeout, 0);
        check("s5_rise_novalid", rv_valid, 0);
        check("s5_rise_state", rv_state, 1);
        send_period(2, 2);
        check("s5_next_valid", rv_valid, 1);
        check("s5_next_period", rv_period, 4);

        // Asynchronous reset while locked, in the middle of a high phase.
        send_period(2, 2);
        send_period(2, 2);
        send_period(2, 2);
        check("s1_pre_locked", rv_locked, 1);
        step(1'b1);
        #2 rstn = 1'b0;
        #1;
        check("s1_async_locked", locked, 0);
        check("s1_async_period", period, 0);
        check("s1_async_high", high_time, 0);
        check("s1_async_errcnt", err_count, 0);
        check("s1_async_state", state_dbg, 0);
        sig_in = 1'b0;
        @(posedge clk_in);
        #1 rstn = 1'b1;
        e0 = err_seen;
        repeat (3) step(1'b0);
        check("s1_post_state", state_dbg, 0);
        check("s1_post_no_err", err_seen - e0, 0);

        // err_count saturation under repeated period-5 faults.
        send_period(2, 3);
        e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            send_period(2, 3);
            if (i == 253) check("s6_errcnt_254", rv_errcnt, 254);
        end
        check("s6_errcnt_sat", err_count, 255);
        check("s6_last_err", rv_err, 1);
        check("s6_err_pulses", err_seen - e0, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
